// File: rtl/tube_time_reader_if.sv
// Host-side link of the tube-time reader: trigger in, mux select/time, byte stream out, status.
interface tube_time_reader_if #(
  parameter int SEL_W  = 2,
  parameter int TIME_W = 8
);
  logic              SCIN_COINC;
  logic [SEL_W-1:0]  CHIP_IN;
  logic [TIME_W-1:0] CHIP_OUT;
  logic [7:0]        TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic              BUSY;
  logic              EVT_DROPPED;
  logic [7:0]        DROP_CNT;

  modport master (
    input  SCIN_COINC, CHIP_OUT, TX_READY,
    output CHIP_IN, TX_DATA, TX_VALID, BUSY, EVT_DROPPED, DROP_CNT
  );

  modport slave (
    output SCIN_COINC, CHIP_OUT, TX_READY,
    input  CHIP_IN, TX_DATA, TX_VALID, BUSY, EVT_DROPPED, DROP_CNT
  );
endinterface

// File: rtl/tube_time_reader.sv
// Polls every tube after a coincidence window and frames the times as bytes (TUBE_READER_CHECKSUM_EN adds an XOR byte).
// Latency: 1 + WINDOW_CYCLES + NUM_TUBES*(SETTLE_CYCLES+1) cycles from trigger to first TX_VALID.
// Backpressure: TX_READY low holds the current byte indefinitely; triggers while busy are dropped and counted.
module tube_time_reader #(
  parameter int         NUM_TUBES     = 4,
  parameter int         SEL_W         = 2,
  parameter int         TIME_W        = 8,
  parameter int         WINDOW_CYCLES = 255,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] HDR_BYTE      = 8'hA5
) (
  input logic               CLK,
  input logic               RST,
  tube_time_reader_if.master bus
);

  localparam int WCNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE,
    WAIT,
    SETTLE,
    CAPTURE,
    SEND_HDR,
    SEND_SEQ,
    SEND_T,
`ifdef TUBE_READER_CHECKSUM_EN
    SEND_CK,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic [SCNT_W-1:0] scnt;
  logic [SEL_W-1:0]  idx;
  logic [7:0]        seq;
  logic              coinc_q;
  logic [TIME_W-1:0] tbuf [NUM_TUBES];

`ifdef TUBE_READER_CHECKSUM_EN
  logic [7:0] ck;

  always_comb begin
    ck = seq;
    for (int i = 0; i < NUM_TUBES; i++) ck = ck ^ tbuf[i];
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      wcnt            <= '0;
      scnt            <= '0;
      idx             <= '0;
      seq             <= '0;
      coinc_q         <= 1'b0;
      for (int i = 0; i < NUM_TUBES; i++) tbuf[i] <= '0;
      bus.CHIP_IN     <= '0;
      bus.TX_DATA     <= '0;
      bus.TX_VALID    <= 1'b0;
      bus.BUSY        <= 1'b0;
      bus.EVT_DROPPED <= 1'b0;
      bus.DROP_CNT    <= '0;
    end else begin
      coinc_q         <= bus.SCIN_COINC;
      bus.EVT_DROPPED <= 1'b0;
      // Only a fresh rising edge while busy counts, so a held level is charged once.
      if (state != IDLE && bus.SCIN_COINC && !coinc_q) begin
        bus.EVT_DROPPED <= 1'b1;
        if (bus.DROP_CNT != 8'hFF) bus.DROP_CNT <= bus.DROP_CNT + 8'd1;
      end

      case (state)
        IDLE: if (bus.SCIN_COINC) begin
          wcnt     <= '0;
          bus.BUSY <= 1'b1;
          state    <= WAIT;
        end
        WAIT: if (wcnt == WCNT_W'(WINDOW_CYCLES - 1)) begin
          idx         <= '0;
          bus.CHIP_IN <= '0;
          scnt        <= '0;
          state       <= SETTLE;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        SETTLE: if (scnt == SCNT_W'(SETTLE_CYCLES - 1)) state <= CAPTURE;
                else scnt <= scnt + 1'b1;
        CAPTURE: begin
          tbuf[idx] <= bus.CHIP_OUT;
          if (idx == SEL_W'(NUM_TUBES - 1)) begin
            bus.TX_DATA  <= HDR_BYTE;
            bus.TX_VALID <= 1'b1;
            state        <= SEND_HDR;
          end else begin
            idx         <= idx + 1'b1;
            bus.CHIP_IN <= idx + 1'b1;
            scnt        <= '0;
            state       <= SETTLE;
          end
        end
        SEND_HDR: if (bus.TX_READY) begin
          bus.TX_DATA <= seq;
          state       <= SEND_SEQ;
        end
        SEND_SEQ: if (bus.TX_READY) begin
          bus.TX_DATA <= tbuf[0];
          idx         <= '0;
          state       <= SEND_T;
        end
        SEND_T: if (bus.TX_READY) begin
          if (idx == SEL_W'(NUM_TUBES - 1)) begin
`ifdef TUBE_READER_CHECKSUM_EN
            bus.TX_DATA  <= ck;
            state        <= SEND_CK;
`else
            bus.TX_VALID <= 1'b0;
            state        <= DONE;
`endif
          end else begin
            idx         <= idx + 1'b1;
            bus.TX_DATA <= tbuf[idx + 1'b1];
          end
        end
`ifdef TUBE_READER_CHECKSUM_EN
        SEND_CK: if (bus.TX_READY) begin
          bus.TX_VALID <= 1'b0;
          state        <= DONE;
        end
`endif
        DONE: begin
          seq      <= seq + 8'd1;
          bus.BUSY <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_time_reader.sv
// Directed bench: default reader (window 255, settle 2) and a short-window reader (window 8, settle 1) behind a delayed mux.
module tb_tube_time_reader;

`ifdef TUBE_READER_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tube_time_reader_if #(.SEL_W(2), .TIME_W(8)) a ();
  tube_time_reader_if #(.SEL_W(2), .TIME_W(8)) b ();

  tube_time_reader u_a (.CLK(clk), .RST(rst_a), .bus(a.master));
  tube_time_reader #(.WINDOW_CYCLES(8), .SETTLE_CYCLES(1)) u_b (.CLK(clk), .RST(rst_b), .bus(b.master));

  logic [7:0] times_a [4];
  logic [7:0] times_b [4];
  logic [7:0] d1, d2;
  int         mux_delay = 1;

  always_comb a.CHIP_OUT = times_a[a.CHIP_IN];

  always @(posedge clk) begin
    d1 <= times_b[b.CHIP_IN];
    d2 <= d1;
  end
  assign b.CHIP_OUT = (mux_delay == 2) ? d2 : d1;

  logic [7:0] qa [$];
  logic [7:0] qb [$];
  bit         stall_prev = 1'b0;
  logic [7:0] stall_dat;
  logic [1:0] chip_hist [0:600];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfers are logged on the falling edge, ahead of the rising edge that completes them.
  always @(negedge clk) begin
    if (rst_a) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("tx_hold_vld", 32'(a.TX_VALID), 32'(1));
        check("tx_hold_dat", 32'(a.TX_DATA), 32'(stall_dat));
      end
      if (a.TX_VALID && a.TX_READY) qa.push_back(a.TX_DATA);
      stall_prev = a.TX_VALID && !a.TX_READY;
      stall_dat  = a.TX_DATA;
    end
    if (!rst_b && b.TX_VALID && b.TX_READY) qb.push_back(b.TX_DATA);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses the trigger for one cycle and returns edges counted until TX_VALID rises.
  task automatic trigger_count(input bit on_b, output int n);
    n = 0;
    if (on_b) b.SCIN_COINC = 1'b1; else a.SCIN_COINC = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      n++;
      a.SCIN_COINC = 1'b0;
      b.SCIN_COINC = 1'b0;
      if (!on_b) chip_hist[n] = a.CHIP_IN;
      if ((on_b ? b.TX_VALID : a.TX_VALID) === 1'b1) break;
    end
  endtask

  task automatic wait_idle(input string tag, input bit on_b, input int bound);
    int n = 0;
    while (((on_b ? b.BUSY : a.BUSY) !== 1'b0) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(on_b ? b.BUSY : a.BUSY), 32'(0));
  endtask

  task automatic expect_frame(input string tag, input bit on_b, input logic [7:0] s,
                              input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] t2, input logic [7:0] t3);
    logic [7:0] exp_b [7];
    logic [7:0] got;
    exp_b = '{8'hA5, s, t0, t1, t2, t3, s ^ t0 ^ t1 ^ t2 ^ t3};
    check({tag, "_len"}, 32'(on_b ? qb.size() : qa.size()), 32'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++) begin
      got = 8'h00;
      if (on_b && qb.size() > 0) got = qb.pop_front();
      if (!on_b && qa.size() > 0) got = qa.pop_front();
      check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp_b[i]));
    end
    qa.delete();
    qb.delete();
  endtask

  int n;
  int nfr;
  int busy_low;

  initial begin
    times_a = '{8'h04, 8'h10, 8'h7F, 8'hFF};
    times_b = '{8'h3C, 8'h5A, 8'h96, 8'hC3};
    a.SCIN_COINC = 1'b0;
    a.TX_READY   = 1'b0;
    b.SCIN_COINC = 1'b0;
    b.TX_READY   = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick(3);
    rst_a = 1'b0;
    rst_b = 1'b0;

    check("rst_vld",  32'(a.TX_VALID),    32'(0));
    check("rst_busy", 32'(a.BUSY),        32'(0));
    check("rst_chip", 32'(a.CHIP_IN),     32'(0));
    check("rst_dat",  32'(a.TX_DATA),     32'(0));
    check("rst_evt",  32'(a.EVT_DROPPED), 32'(0));
    check("rst_drop", 32'(a.DROP_CNT),    32'(0));

    // Basic frame, ready held high.
    a.TX_READY = 1'b1;
    trigger_count(1'b0, n);
    check("lat_a", 32'(n), 32'(268));
    check("first_hdr", 32'(a.TX_DATA), 32'(8'hA5));
    check("chip_258", 32'(chip_hist[258]), 32'(0));
    check("chip_259", 32'(chip_hist[259]), 32'(1));
    check("chip_261", 32'(chip_hist[261]), 32'(1));
    check("chip_262", 32'(chip_hist[262]), 32'(2));
    check("chip_264", 32'(chip_hist[264]), 32'(2));
    check("chip_265", 32'(chip_hist[265]), 32'(3));
    wait_idle("basic", 1'b0, 50);
    expect_frame("basic", 1'b0, 8'h00, 8'h04, 8'h10, 8'h7F, 8'hFF);

    // Backpressure: ready high one cycle in four.
    a.SCIN_COINC = 1'b1;
    a.TX_READY   = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      a.SCIN_COINC = 1'b0;
      a.TX_READY   = (i % 4 == 3);
      if (i > 300 && a.BUSY === 1'b0) break;
    end
    a.TX_READY = 1'b1;
    wait_idle("bp", 1'b0, 10);
    expect_frame("bp", 1'b0, 8'h01, 8'h04, 8'h10, 8'h7F, 8'hFF);

    // Retrigger 50 cycles into the window.
    a.SCIN_COINC = 1'b1;
    tick();
    a.SCIN_COINC = 1'b0;
    check("trig_no_drop", 32'(a.EVT_DROPPED), 32'(0));
    tick(50);
    check("retrig_busy", 32'(a.BUSY), 32'(1));
    a.SCIN_COINC = 1'b1;
    tick();
    check("drop_pulse", 32'(a.EVT_DROPPED), 32'(1));
    check("drop_cnt1",  32'(a.DROP_CNT),    32'(1));
    a.SCIN_COINC = 1'b0;
    tick();
    check("drop_pulse_end", 32'(a.EVT_DROPPED), 32'(0));
    wait_idle("retrig", 1'b0, 400);
    expect_frame("retrig", 1'b0, 8'h02, 8'h04, 8'h10, 8'h7F, 8'hFF);
    tick(300);
    check("no_queued_busy", 32'(a.BUSY), 32'(0));
    check("no_queued_bytes", 32'(qa.size()), 32'(0));

    // Hundreds of rising edges while busy saturate the drop counter.
    for (int i = 1; i < 800; i++) begin
      a.SCIN_COINC = i[0];
      tick();
    end
    a.SCIN_COINC = 1'b0;
    wait_idle("drops", 1'b0, 600);
    check("drop_sat", 32'(a.DROP_CNT), 32'(255));
    qa.delete();

    // Reset while the third time byte is presented.
    times_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    a.TX_READY = 1'b0;
    trigger_count(1'b0, n);
    check("lat_rst", 32'(n), 32'(268));
    a.TX_READY = 1'b1;
    tick(4);
    a.TX_READY = 1'b0;
    check("pre_rst_dat", 32'(a.TX_DATA), 32'(8'h33));
    check("pre_rst_cnt", 32'(qa.size()), 32'(4));
    rst_a = 1'b1;
    tick();
    check("mid_rst_vld",  32'(a.TX_VALID), 32'(0));
    check("mid_rst_busy", 32'(a.BUSY),     32'(0));
    check("mid_rst_chip", 32'(a.CHIP_IN),  32'(0));
    check("mid_rst_drop", 32'(a.DROP_CNT), 32'(0));
    rst_a = 1'b0;
    a.TX_READY = 1'b1;
    tick(3);
    check("no_bytes_after_rst", 32'(qa.size()), 32'(4));
    qa.delete();
    trigger_count(1'b0, n);
    wait_idle("post_rst", 1'b0, 50);
    expect_frame("post_rst", 1'b0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44);

    // Short-settle reader: a 1-cycle mux delay is tolerated, 2 cycles shifts every capture.
    b.TX_READY = 1'b1;
    mux_delay  = 1;
    trigger_count(1'b1, n);
    check("lat_b", 32'(n), 32'(17));
    wait_idle("sel1", 1'b1, 50);
    expect_frame("sel1", 1'b1, 8'h00, 8'h3C, 8'h5A, 8'h96, 8'hC3);
    mux_delay = 2;
    trigger_count(1'b1, n);
    wait_idle("sel2", 1'b1, 50);
    expect_frame("sel2", 1'b1, 8'h01, 8'hC3, 8'h3C, 8'h5A, 8'h96);

    // Sequence wrap: trigger held high, 257 back-to-back frames.
    mux_delay = 1;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    qb.delete();
    b.SCIN_COINC = 1'b1;
    nfr = 0;
    busy_low = 0;
    for (int i = 0; i < 12000 && nfr < 257; i++) begin
      tick();
      if (b.BUSY === 1'b0) busy_low++;
      if (qb.size() >= FRAME_LEN) begin
        check("wrap_hdr", 32'(qb[0]), 32'(8'hA5));
        check("wrap_seq", 32'(qb[1]), 32'(nfr[7:0]));
        repeat (FRAME_LEN) void'(qb.pop_front());
        nfr++;
      end
    end
    b.SCIN_COINC = 1'b0;
    check("wrap_frames", 32'(nfr), 32'(257));
    check("wrap_busy_gaps", 32'(busy_low >= 256), 32'(1));
    check("wrap_no_drops", 32'(b.DROP_CNT), 32'(0));
    tick(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_time_reader.md
Name: tube_time_reader

Overview:
- Host-side reader for the tube-time mux: drives the tube select (CHIP_IN) and samples the returned 8-bit tube time (CHIP_OUT).
- Each scintillator coincidence triggers one readout. After the timing window closes, the block polls every tube and buffers the times.
- The buffered times are emitted as a byte frame over a valid/ready link toward the host serializer.

Parameters:
- NUM_TUBES, 4, number of tubes polled per event (max 2**SEL_W).
- SEL_W, 2, width of tube select.
- TIME_W, 8, width of tube time word; fixed to 8 so one time equals one byte.
- WINDOW_CYCLES, 255, CLK cycles to wait after trigger before polling; must be at least the timing counter maximum.
- SETTLE_CYCLES, 2, cycles CHIP_IN is held before CHIP_OUT is sampled (minimum 1).
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- SCIN_COINC  in  1  scintillator coincidence, level-sampled on CLK.
- CHIP_IN  out  SEL_W  tube select driven to the tube-time mux.
- CHIP_OUT  in  TIME_W  tube time returned for the selected tube.
- TX_DATA  out  8  frame byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  downstream accepts byte.
- BUSY  out  1  high in any state other than IDLE.
- EVT_DROPPED  out  1  one-cycle pulse when a trigger is ignored.
- DROP_CNT  out  8  count of ignored triggers, saturates at 255.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state=IDLE, CHIP_IN=0, TX_DATA=0, TX_VALID=0, BUSY=0, EVT_DROPPED=0, DROP_CNT=0.
  - seq=0, tube buffer = all 0.
- RST has priority over every other input on the same edge. Asserting RST mid-frame aborts the frame immediately and no further bytes are sent.
- States and transitions:
  - IDLE: if SCIN_COINC=1, go to WAIT; clear wcnt.
  - WAIT: increment wcnt each cycle; on wcnt==WINDOW_CYCLES-1, set idx=0, CHIP_IN=0, scnt=0, go to SETTLE.
  - SETTLE: increment scnt; on scnt==SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE: buf[idx]<=CHIP_OUT, sampled on this edge.
    - If idx==NUM_TUBES-1, go to SEND_HDR.
    - Otherwise idx++, CHIP_IN<=idx+1, scnt=0, go to SETTLE.
  - SEND_HDR, SEND_SEQ, SEND_T (idx 0..NUM_TUBES-1), then SEND_CK if enabled: each state presents one byte.
  - DONE: seq<=seq+1 (wraps 255->0); go to IDLE.
- Trigger-to-first-TX_VALID latency: 1 + WINDOW_CYCLES + NUM_TUBES*(SETTLE_CYCLES+1) cycles.
- Handshake:
  - A byte transfers on a posedge where TX_VALID&&TX_READY.
  - TX_DATA and TX_VALID stay stable until that transfer; TX_VALID never drops without a transfer.
  - The next byte's TX_VALID may be high the cycle after a transfer, so back-to-back bytes take 1 cycle each with TX_READY held high.
  - TX_READY low stalls indefinitely; no timeout.
- Frame order: HDR_BYTE, seq, buf[0..NUM_TUBES-1], then the checksum if enabled.
- Retrigger: SCIN_COINC=1 while state!=IDLE is not queued.
  - Ignored, but only on its rising edge: EVT_DROPPED pulses 1 cycle and DROP_CNT++ (holds at 255).
  - A level held high across a readout counts once.
- SCIN_COINC still high when DONE returns to IDLE: counts as a new trigger on the next cycle.
- CHIP_IN holds its last value in IDLE and WAIT; reset value is 0.

Optional Feature:
- Macro: TUBE_READER_CHECKSUM_EN.
- Defined: after the last time byte, one extra byte is sent: XOR of seq and all buf bytes; HDR_BYTE is excluded. Frame length = NUM_TUBES+3.
- Undefined: no checksum state exists. Frame length = NUM_TUBES+2; DONE follows the last time byte.

Test Plan:
- Basic frame (defaults): mux returns times 8'h04,8'h10,8'h7F,8'hFF for select 0..3; one SCIN_COINC pulse, TX_READY=1.
  -> bytes A5,00,04,10,7F,FF (+ checksum 8'h94 if enabled).
  -> first TX_VALID exactly 268 cycles after trigger; CHIP_IN steps 0,1,2,3 with 3 cycles per tube.
- Backpressure: same stimulus, TX_READY toggled 1 cycle high / 3 low.
  -> identical byte sequence; TX_DATA stable whenever TX_VALID && !TX_READY.
- Sequence wrap: 257 back-to-back events.
  -> seq bytes run 00..FF then 00; BUSY falls for at least 1 cycle between frames.
- Retrigger: second SCIN_COINC pulse 50 cycles into WAIT.
  -> EVT_DROPPED 1-cycle pulse, DROP_CNT=1, only one frame emitted.
  -> 300 drops leave DROP_CNT=255.
- Reset mid-frame: RST asserted during SEND_T with idx=2.
  -> next cycle TX_VALID=0, BUSY=0, CHIP_IN=0, seq=0; the next event's frame starts with A5,00.
- Select timing check: mux models a 1-cycle output delay, SETTLE_CYCLES=1.
  -> captured values match the per-tube times; with the mux delay set to 2 cycles the bench flags a mismatch.
